sc_regtime_speed_step: RTL and testbench
========================================

// Module: sc_regtime_speed_step
// PURPOSE
// - Consumer of the game elapsed-seconds bus from the seconds counter register.
// - Decodes elapsed time into a speed phase.
// - Emits one-cycle movement-step pulses at the period assigned to that phase.
// - Counts the steps issued and flags end of race at 61 s. Feeds the road/car position logic.
// PARAMETERS
// - TIME_DATAWIDTH  8           width of elapsed-seconds input
// - CNT_W           25          prescaler width; must hold the largest period minus 1
// - PERIOD_P0       17_500_000  clocks per step in phase 0 (0.35 s @ 50 MHz)
// - PERIOD_P2       14_000_000  clocks per step in phase 2 (0.28 s)
// - PERIOD_P4       10_000_000  clocks per step in phase 4 (0.20 s)
// - END_TIME        61          seconds at which race ends
// PORTS
// - SC_RegGENERAL_CLOCK_50       in   1   system clock, 50 MHz
// - SC_RegGENERAL_RESET_InHigh   in   1   asynchronous, active-high reset
// - SC_RegGENERAL_START_InHigh   in   1   level: 1 = race running, 0 = stop/pause
// - SC_SpeedStep_TIME_InBUS      in   TIME_DATAWIDTH   elapsed seconds, unsigned
// - SC_SpeedStep_STEP_Out        out  1   one-cycle movement-step pulse
// - SC_SpeedStep_PHASE_OutBUS    out  3   current phase 0..4
// - SC_SpeedStep_COUNT_OutBUS    out  16  steps issued since last start
// - SC_SpeedStep_DONE_Out        out  1   race finished
// BEHAVIOUR
// - Reset: state=IDLE, STEP=0, PHASE=0, COUNT=0, DONE=0, prescaler=0.
// - Phase decode (combinational, from TIME):
//   - t<=10 -> phase 0
//   - 11..17 -> phase 1 (hold)
//   - 18..32 -> phase 2
//   - 33..40 -> phase 3 (hold)
//   - 41..60 -> phase 4
//   - t>=END_TIME -> end condition
// - PHASE output: registered decode, 1-cycle latency. It updates in every state except DONE.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: START=1 -> RUN; prescaler and COUNT cleared on that transition.
//   - RUN: START=0 -> IDLE (prescaler cleared, COUNT kept); end condition -> DONE.
//     If START=0 and the end condition occur in the same cycle, IDLE wins.
//   - DONE: DONE=1, no steps, PHASE frozen. START=0 -> IDLE (DONE clears).
// - Prescaler, RUN state, active phase (0/2/4):
//   - Increments every clock.
//   - At PERIOD_Px-1: STEP=1 for exactly one cycle, prescaler wraps to 0.
//   - First step comes PERIOD_Px clocks after entering RUN or entering the phase.
// - Prescaler, hold phase (1/3): held at 0, STEP=0.
// - Phase change (registered PHASE differs from decode):
//   - Prescaler forced to 0 that cycle.
//   - A terminal count on the same cycle is discarded (no STEP).
// - TIME decreasing (upstream counter cleared): phase follows the decode. No special handling.
// - COUNT: increments with each STEP, saturates at 16'hFFFF, never wraps.
// - STEP is registered: asserted the cycle after the terminal count. It is never high outside RUN.
// - Reset mid-operation: all outputs return to reset values asynchronously.
// STRUCTURE
// - Shared package sc_roadfighter_pkg holds:
//   - phase encodings PH_0..PH_4
//   - FSM state encodings
//   - bracket bounds 10/17/32/40/60 and END_TIME default
// - Sub-module sc_step_prescaler: loadable period, clear, enable; terminal-count pulse out.
// - Top holds decode, FSM, COUNT and output registers.
// TESTING (sim overrides: PERIOD_P0=7, PERIOD_P2=5, PERIOD_P4=3, CNT_W=4)
// - Reset, TIME=0, START=1 for 30 clk -> PHASE=0, STEP every 7 clk, COUNT=4.
// - TIME steps 5 -> 12 -> 20 -> 35 -> 45, 20 clk each, START=1:
//   - PHASE follows 0, 1, 2, 3, 4 with 1-clk lag.
//   - No STEP during phases 1 and 3.
//   - Step periods 5 and 3 clk in phases 2 and 4.
// - Phase 0 -> 2 change lands on the prescaler terminal cycle -> no STEP that cycle; next STEP 5 clk later.
// - TIME=61 while in RUN -> DONE=1, STEP stays 0, PHASE frozen.
//   START=0 -> DONE=0, state IDLE. START=1 -> COUNT=0.
// - START dropped for 10 clk mid-phase 4, then raised -> COUNT unchanged; first STEP 3 clk after restart.
// - RESET pulsed asynchronously mid-RUN -> STEP, PHASE, COUNT, DONE at 0 immediately;
//   COUNT saturation forced via long run -> holds 16'hFFFF.

Source files
------------

// File: rtl/sc_roadfighter_pkg.sv
// Shared Road Fighter definitions: phase and FSM encodings, time bracket bounds, phase decode.
package sc_roadfighter_pkg;

  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned BOUND_P0     = 10;
  localparam int unsigned BOUND_P1     = 17;
  localparam int unsigned BOUND_P2     = 32;
  localparam int unsigned BOUND_P3     = 40;
  localparam int unsigned BOUND_P4     = 60;
  localparam int unsigned END_TIME_DEF = 61;

  // Times past the last bracket stay in phase 4; the end condition is decoded separately.
  function automatic phase_e decodePhase(input logic [31:0] t);
    if (t <= BOUND_P0)      return PH_0;
    else if (t <= BOUND_P1) return PH_1;
    else if (t <= BOUND_P2) return PH_2;
    else if (t <= BOUND_P3) return PH_3;
    else                    return PH_4;
  endfunction

endpackage

// File: rtl/sc_regtime_speed_step_if.sv
// Elapsed-time in / movement-step out bundle between the seconds register and the speed stepper.
interface sc_regtime_speed_step_if #(
  parameter int unsigned TIME_DATAWIDTH = 8
);
  logic                      SC_RegGENERAL_START_InHigh;
  logic [TIME_DATAWIDTH-1:0] SC_SpeedStep_TIME_InBUS;
  logic                      SC_SpeedStep_STEP_Out;
  logic [2:0]                SC_SpeedStep_PHASE_OutBUS;
  logic [15:0]               SC_SpeedStep_COUNT_OutBUS;
  logic                      SC_SpeedStep_DONE_Out;

  modport master (
    output SC_RegGENERAL_START_InHigh, SC_SpeedStep_TIME_InBUS,
    input  SC_SpeedStep_STEP_Out, SC_SpeedStep_PHASE_OutBUS,
           SC_SpeedStep_COUNT_OutBUS, SC_SpeedStep_DONE_Out
  );

  modport slave (
    input  SC_RegGENERAL_START_InHigh, SC_SpeedStep_TIME_InBUS,
    output SC_SpeedStep_STEP_Out, SC_SpeedStep_PHASE_OutBUS,
           SC_SpeedStep_COUNT_OutBUS, SC_SpeedStep_DONE_Out
  );
endinterface

// File: rtl/sc_step_prescaler.sv
// Step prescaler: counts to a loadable period and flags the terminal cycle; clear has priority.
module sc_step_prescaler #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             SC_RegGENERAL_CLOCK_50,
  input  logic             SC_RegGENERAL_RESET_InHigh,
  input  logic [CNT_W-1:0] period,
  input  logic             clear,
  input  logic             enable,
  output logic             tcPulse_c
);

  logic [CNT_W-1:0] cnt;

  assign tcPulse_c = enable && !clear && (cnt == period - CNT_W'(1));

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tcPulse_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sc_regtime_speed_step.sv
// Speed stepper: decodes elapsed seconds into a speed phase and issues movement-step pulses.
module sc_regtime_speed_step
  import sc_roadfighter_pkg::*;
#(
  parameter int unsigned TIME_DATAWIDTH = 8,
  parameter int unsigned CNT_W          = 25,
  parameter int unsigned PERIOD_P0      = 17_500_000,
  parameter int unsigned PERIOD_P2      = 14_000_000,
  parameter int unsigned PERIOD_P4      = 10_000_000,
  parameter int unsigned END_TIME       = END_TIME_DEF
) (
  input logic              SC_RegGENERAL_CLOCK_50,
  input logic              SC_RegGENERAL_RESET_InHigh,
  sc_regtime_speed_step_if.slave speedIf
);

  logic [TIME_DATAWIDTH-1:0] timeVal;
  logic                      startVal;
  state_e                    state, nextState;
  phase_e                    phaseDec, phaseReg;
  logic                      endCond, phaseChange, holdPhase;
  logic                      preEnable, preClear, tcPulse_c;
  logic [CNT_W-1:0]          period;
  logic                      stepReg, doneReg;
  logic [15:0]               countReg;

  assign timeVal     = speedIf.SC_SpeedStep_TIME_InBUS;
  assign startVal    = speedIf.SC_RegGENERAL_START_InHigh;
  assign phaseDec    = decodePhase(32'(timeVal));
  assign endCond     = 32'(timeVal) >= END_TIME;
  assign phaseChange = (phaseReg != phaseDec);
  assign holdPhase   = (phaseReg == PH_1) || (phaseReg == PH_3);

  always_comb begin
    period = CNT_W'(PERIOD_P0);
    case (phaseReg)
      PH_2:    period = CNT_W'(PERIOD_P2);
      PH_4:    period = CNT_W'(PERIOD_P4);
      default: period = CNT_W'(PERIOD_P0);
    endcase
  end

  // Next state; a pause request outranks the end of race.
  always_comb begin
    nextState = state;
    preEnable = 1'b0;
    case (state)
      ST_IDLE: if (startVal) nextState = ST_RUN;
      ST_RUN: begin
        if (!startVal)    nextState = ST_IDLE;
        else if (endCond) nextState = ST_DONE;
      end
      ST_DONE: if (!startVal) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
    // Counting only while staying in RUN on a settled, active phase; anything else restarts it.
    preEnable = (state == ST_RUN) && (nextState == ST_RUN) && !phaseChange && !holdPhase;
  end

  assign preClear = !preEnable;

  sc_step_prescaler #(.CNT_W(CNT_W)) uPrescaler (
    .SC_RegGENERAL_CLOCK_50     (SC_RegGENERAL_CLOCK_50),
    .SC_RegGENERAL_RESET_InHigh (SC_RegGENERAL_RESET_InHigh),
    .period                     (period),
    .clear                      (preClear),
    .enable                     (preEnable),
    .tcPulse_c                  (tcPulse_c)
  );

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      state    <= ST_IDLE;
      phaseReg <= PH_0;
      stepReg  <= 1'b0;
      doneReg  <= 1'b0;
      countReg <= '0;
    end else begin
      state   <= nextState;
      stepReg <= tcPulse_c;
      doneReg <= (nextState == ST_DONE);
      if (state != ST_DONE) phaseReg <= phaseDec;
      if (state == ST_IDLE && nextState == ST_RUN) countReg <= '0;
      else if (tcPulse_c && countReg != 16'hFFFF) countReg <= countReg + 16'd1;
    end
  end

  assign speedIf.SC_SpeedStep_STEP_Out     = stepReg;
  assign speedIf.SC_SpeedStep_PHASE_OutBUS = phaseReg;
  assign speedIf.SC_SpeedStep_COUNT_OutBUS = countReg;
  assign speedIf.SC_SpeedStep_DONE_Out     = doneReg;

endmodule

// File: tb/tb_sc_regtime_speed_step.sv
// Bench for sc_regtime_speed_step: directed and random stimulus against a step-timing model.
module tb_sc_regtime_speed_step;

  logic clk = 1'b0;
  logic rst;
  logic rstSat;
  int   cyc = 0;
  int   nAsserts = 0;
  int   fails = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc_regtime_speed_step_if #(.TIME_DATAWIDTH(8)) dutIf ();
  sc_regtime_speed_step_if #(.TIME_DATAWIDTH(8)) satIf ();

  sc_regtime_speed_step #(
    .TIME_DATAWIDTH(8), .CNT_W(4), .PERIOD_P0(7), .PERIOD_P2(5), .PERIOD_P4(3), .END_TIME(61)
  ) dut (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .speedIf                    (dutIf.slave)
  );

  // Period-1 instance: steps every clock so COUNT saturation is reachable in a short run.
  sc_regtime_speed_step #(
    .TIME_DATAWIDTH(8), .CNT_W(4), .PERIOD_P0(1), .PERIOD_P2(1), .PERIOD_P4(1), .END_TIME(61)
  ) dutSat (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rstSat),
    .speedIf                    (satIf.slave)
  );

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int   mState, mPhase, mCount, mAnchor;
  logic mStep;

  function automatic int mDecode(input int t);
    if (t <= 10) return 0;
    if (t <= 17) return 1;
    if (t <= 32) return 2;
    if (t <= 40) return 3;
    return 4;
  endfunction

  function automatic int mPeriod(input int ph);
    case (ph)
      0:       return 7;
      2:       return 5;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  // Reference: a step lands every P clocks counted from the edge that entered RUN or the phase.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mState <= M_IDLE; mPhase <= 0; mCount <= 0; mStep <= 1'b0; mAnchor <= 0;
    end else begin
      mStep <= 1'b0;
      case (mState)
        M_IDLE: begin
          mPhase <= mDecode(int'(dutIf.SC_SpeedStep_TIME_InBUS));
          if (dutIf.SC_RegGENERAL_START_InHigh) begin
            mState <= M_RUN; mAnchor <= cyc; mCount <= 0;
          end
        end
        M_RUN: begin
          mPhase <= mDecode(int'(dutIf.SC_SpeedStep_TIME_InBUS));
          if (!dutIf.SC_RegGENERAL_START_InHigh) mState <= M_IDLE;
          else if (int'(dutIf.SC_SpeedStep_TIME_InBUS) >= 61) mState <= M_DONE;
          else if (mDecode(int'(dutIf.SC_SpeedStep_TIME_InBUS)) != mPhase) mAnchor <= cyc;
          else if (mPeriod(mPhase) != 0 && ((cyc - mAnchor) % mPeriod(mPhase)) == 0) begin
            mStep <= 1'b1;
            if (mCount < 65535) mCount <= mCount + 1;
          end
        end
        default: if (!dutIf.SC_RegGENERAL_START_InHigh) mState <= M_IDLE;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    chk("model_step",  32'(dutIf.SC_SpeedStep_STEP_Out),     32'(mStep));
    chk("model_phase", 32'(dutIf.SC_SpeedStep_PHASE_OutBUS), 32'(mPhase));
    chk("model_count", 32'(dutIf.SC_SpeedStep_COUNT_OutBUS), 32'(mCount));
    chk("model_done",  32'(dutIf.SC_SpeedStep_DONE_Out),     32'(mState == M_DONE));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    checkModel();
  endtask

  task automatic setIn(input logic start, input int t);
    dutIf.SC_RegGENERAL_START_InHigh = start;
    dutIf.SC_SpeedStep_TIME_InBUS    = 8'(t);
  endtask

  int segTime[5]   = '{5, 12, 20, 35, 45};
  int segPhase[5]  = '{0, 1, 2, 3, 4};
  int segSteps[5]  = '{3, 0, 3, 0, 6};
  int stepSeen;
  int savedCount;
  int segLeft;

  initial begin
    rst = 1'b1; rstSat = 1'b1;
    setIn(1'b0, 0);
    satIf.SC_RegGENERAL_START_InHigh = 1'b1;
    satIf.SC_SpeedStep_TIME_InBUS    = 8'd0;
    #5;
    chk("reset_step",  32'(dutIf.SC_SpeedStep_STEP_Out),     32'd0);
    chk("reset_phase", 32'(dutIf.SC_SpeedStep_PHASE_OutBUS), 32'd0);
    chk("reset_count", 32'(dutIf.SC_SpeedStep_COUNT_OutBUS), 32'd0);
    chk("reset_done",  32'(dutIf.SC_SpeedStep_DONE_Out),     32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; rstSat = 1'b0;

    // Phase 0 run from reset.
    setIn(1'b1, 0);
    repeat (30) tick();
    chk("p0_count", 32'(dutIf.SC_SpeedStep_COUNT_OutBUS), 32'd4);
    chk("p0_phase", 32'(dutIf.SC_SpeedStep_PHASE_OutBUS), 32'd0);

    // Walk through all five phases.
    for (int i = 0; i < 5; i++) begin
      setIn(1'b1, segTime[i]);
      #1;
      chk("phase_lag", 32'(dutIf.SC_SpeedStep_PHASE_OutBUS), 32'(segPhase[(i == 0) ? 0 : i - 1]));
      stepSeen = 0;
      repeat (20) begin
        tick();
        if (dutIf.SC_SpeedStep_STEP_Out === 1'b1) stepSeen++;
      end
      chk("seg_phase", 32'(dutIf.SC_SpeedStep_PHASE_OutBUS), 32'(segPhase[i]));
      chk("seg_steps", 32'(stepSeen), 32'(segSteps[i]));
    end

    // End of race: DONE with frozen phase, then release and restart.
    setIn(1'b1, 61);
    tick();
    chk("done_set", 32'(dutIf.SC_SpeedStep_DONE_Out), 32'd1);
    setIn(1'b1, 5);
    stepSeen = 0;
    repeat (5) begin
      tick();
      if (dutIf.SC_SpeedStep_STEP_Out !== 1'b0) stepSeen++;
    end
    chk("done_nostep", 32'(stepSeen), 32'd0);
    chk("done_frozen", 32'(dutIf.SC_SpeedStep_PHASE_OutBUS), 32'd4);
    chk("done_hold",   32'(dutIf.SC_SpeedStep_DONE_Out), 32'd1);
    setIn(1'b0, 5);
    tick();
    chk("done_clear", 32'(dutIf.SC_SpeedStep_DONE_Out), 32'd0);
    setIn(1'b1, 5);
    tick();
    chk("restart_count", 32'(dutIf.SC_SpeedStep_COUNT_OutBUS), 32'd0);

    // Phase 0 -> 2 change landing on the terminal cycle.
    setIn(1'b0, 0);
    tick(); tick();
    setIn(1'b1, 0);
    tick();
    repeat (6) tick();
    setIn(1'b1, 20);
    tick();
    chk("tc_discard", 32'(dutIf.SC_SpeedStep_STEP_Out), 32'd0);
    repeat (4) tick();
    chk("tc_early", 32'(dutIf.SC_SpeedStep_STEP_Out), 32'd0);
    tick();
    chk("tc_next", 32'(dutIf.SC_SpeedStep_STEP_Out), 32'd1);

    // Pause in phase 4 keeps COUNT; restart times from scratch.
    setIn(1'b1, 45);
    repeat (10) tick();
    savedCount = mCount;
    setIn(1'b0, 45);
    repeat (10) tick();
    chk("pause_count", 32'(dutIf.SC_SpeedStep_COUNT_OutBUS), 32'(savedCount));
    setIn(1'b1, 45);
    tick();
    chk("resume_0", 32'(dutIf.SC_SpeedStep_STEP_Out), 32'd0);
    tick(); tick();
    chk("resume_2", 32'(dutIf.SC_SpeedStep_STEP_Out), 32'd0);
    tick();
    chk("resume_3", 32'(dutIf.SC_SpeedStep_STEP_Out), 32'd1);

    // Random time/start traffic.
    segLeft = 0;
    repeat (300) begin
      if (segLeft == 0) begin
        setIn($urandom_range(0, 9) != 0, int'($urandom_range(0, 70)));
        segLeft = int'($urandom_range(1, 15));
      end
      segLeft--;
      tick();
    end

    // Asynchronous reset in the middle of a run.
    setIn(1'b1, 45);
    repeat (8) tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_step",  32'(dutIf.SC_SpeedStep_STEP_Out),     32'd0);
    chk("arst_phase", 32'(dutIf.SC_SpeedStep_PHASE_OutBUS), 32'd0);
    chk("arst_count", 32'(dutIf.SC_SpeedStep_COUNT_OutBUS), 32'd0);
    chk("arst_done",  32'(dutIf.SC_SpeedStep_DONE_Out),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) tick();

    // Saturation on the period-1 instance.
    while (cyc < 60000) @(negedge clk);
    chk("sat_below", 32'(satIf.SC_SpeedStep_COUNT_OutBUS < 16'hFFFF), 32'd1);
    while (cyc < 66000) @(negedge clk);
    chk("sat_reach", 32'(satIf.SC_SpeedStep_COUNT_OutBUS), 32'h0000FFFF);
    repeat (20) @(negedge clk);
    chk("sat_hold", 32'(satIf.SC_SpeedStep_COUNT_OutBUS), 32'h0000FFFF);
    chk("sat_step", 32'(satIf.SC_SpeedStep_STEP_Out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, fails);
    $finish;
  end

endmodule
